dm_arbiter: RTL and testbench

- Shares the single-port 4096-word data memory between two requesters. Port 0 is the CPU MEM stage; port 1 is the debug/DMA loader.
- Fixed priority to port 0, with a starvation counter that forces a port-1 grant after a bounded wait.
- Issues one memory access per cycle and returns registered read data with a one-cycle response.
- Sits between the pipeline MEM stage and the DM array.

---
 rtl/dm_arbiter.sv | 134 +++++++++++++
 tb/tb_dm_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 (MEM stage) has priority; port 1 is forced through after a bounded wait.
module dm_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] starve_cnt;
  logic          force1;
  logic          any_gnt;
  logic          in_range;

  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;

  logic          rsp_port;
  logic          rsp_err;
  logic [31:0]   rsp_data;

  logic          unused_lsb;

  assign force1  = (starve_cnt == CW'(STARVE_LIMIT));

  // Grants are gated by reset so nothing reaches memory while in reset.
  assign m1_gnt  = reset & m1_req & (~m0_req | force1);
  assign m0_gnt  = reset & m0_req & ~m1_gnt;
  assign any_gnt = m0_gnt | m1_gnt;

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_be    = '0;
    unique case (1'b1)
      m0_gnt: begin
        w_we    = m0_we;
        w_addr  = m0_addr;
        w_wdata = m0_wdata;
        w_be    = m0_be;
      end
      m1_gnt: begin
        w_we    = m1_we;
        w_addr  = m1_addr;
        w_wdata = m1_wdata;
        w_be    = m1_be;
      end
      default: ;
    endcase
  end

  assign in_range   = (w_addr[31:ADDR_W+2] == '0);
  assign unused_lsb = ^w_addr[1:0];

  assign mem_en    = any_gnt & in_range;
  assign mem_we    = w_we & mem_en;
  assign mem_addr  = w_addr[ADDR_W+1:2];
  assign mem_wdata = w_wdata;
  assign mem_be    = w_be;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = any_gnt ? RESP : IDLE;
      RESP:    state_nx = any_gnt ? RESP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rsp_port   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state <= state_nx;
      if (any_gnt) begin
        rsp_port <= m1_gnt;
        rsp_err  <= ~in_range;
        rsp_data <= in_range ? mem_rdata : 32'h0;
      end
      if (!m1_req || m1_gnt) begin
        starve_cnt <= '0;
      end else if (!force1) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign m0_rvalid = (state == RESP) & ~rsp_port;
  assign m1_rvalid = (state == RESP) & rsp_port;
  assign m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
  assign m1_rdata  = m1_rvalid ? rsp_data : 32'h0;
  assign m0_err    = m0_rvalid & rsp_err;
  assign m1_err    = m1_rvalid & rsp_err;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised scoreboard bench for dm_arbiter with a word-array memory.
// Expected responses are queued at grant time and popped by a monitor.
module tb_dm_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    int          cyc;
    bit          port;
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 0;
  logic        reset = 0;
  logic        m0_req = 0, m0_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic [3:0]  m0_be = 0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 0, m1_we = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m1_be = 0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] mem [4096];
  logic        mem_clr = 1;
  logic        poke_en = 0;
  logic [11:0] poke_addr = 0;
  logic [31:0] poke_data = 0;

  logic [31:0] ref_mem [4096];
  int          m1_wait;
  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          done = 0;

  dm_arbiter #(.ADDR_W(12), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic txn_t none();
    txn_t t = '0;
    return t;
  endfunction

  function automatic txn_t rd(input logic [31:0] a);
    txn_t t = '0;
    t.req = 1; t.addr = a; t.be = 4'hF;
    return t;
  endfunction

  function automatic txn_t wr(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
    txn_t t = '0;
    t.req = 1; t.we = 1; t.addr = a; t.wdata = d; t.be = be;
    return t;
  endfunction

  // One clock: drive both ports, predict grant/memory drive, queue response.
  task automatic step(input txn_t a, input txn_t b, input bit rn,
                      output bit g0, output bit g1);
    txn_t  w;
    bit    inr;
    exp_t  e;
    int    idx;
    @(posedge clk);
    #1;
    reset = rn;
    m0_req = a.req; m0_we = a.we; m0_addr = a.addr;
    m0_wdata = a.wdata; m0_be = a.be;
    m1_req = b.req; m1_we = b.we; m1_addr = b.addr;
    m1_wdata = b.wdata; m1_be = b.be;
    #3;
    g0 = 0; g1 = 0;
    if (rn) begin
      g1 = b.req && (!a.req || m1_wait >= LIMIT);
      g0 = a.req && !g1;
    end
    if (!rn) m1_wait = 0;
    else if (b.req && !g1) m1_wait = (m1_wait < LIMIT) ? m1_wait + 1 : LIMIT;
    else m1_wait = 0;
    w = g1 ? b : (g0 ? a : none());
    inr = (w.addr[31:14] == 0);
    idx = int'(w.addr[13:2]);
    chk("m0_gnt", m0_gnt, g0);
    chk("m1_gnt", m1_gnt, g1);
    chk("mem_en", mem_en, (g0 || g1) && inr);
    chk("mem_we", mem_we, (g0 || g1) && inr && w.we);
    if (g0 || g1) begin
      chk("mem_addr", mem_addr, w.addr[13:2]);
      chk("mem_wdata", mem_wdata, w.wdata);
      chk("mem_be", mem_be, w.be);
      e.cyc = cyc; e.port = g1; e.err = !inr;
      e.data = inr ? ref_mem[idx] : 32'h0;
      sb.push_back(e);
      if (inr && w.we)
        for (int k = 0; k < 4; k++)
          if (w.be[k]) ref_mem[idx][8*k +: 8] = w.wdata[8*k +: 8];
    end else begin
      chk("mem_addr_idle", mem_addr, 12'h0);
      chk("mem_be_idle", mem_be, 4'h0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (m0_rvalid && m1_rvalid) begin
        n_vec++; n_err++;
        $display("FAIL both_rvalid @cyc %0d: got 1,1 want one", cyc);
      end else if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_rvalid @cyc %0d: got %b%b want 00",
                   cyc, m1_rvalid, m0_rvalid);
        end else begin
          e = sb.pop_front();
          chk("rsp_port", m1_rvalid, e.port);
          chk("rsp_err", e.port ? m1_err : m0_err, e.err);
          chk("rsp_data", e.port ? m1_rdata : m0_rdata, e.data);
          chk("idle_rdata", e.port ? m0_rdata : m1_rdata, 32'h0);
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        n_vec++; n_err++;
        $display("FAIL missing_rvalid @cyc %0d: got 0 want 1 port %0d",
                 cyc, e.port);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit   g0, g1;
    txn_t p0, p1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    m1_wait = 0;

    step(rd(32'h40), none(), 0, g0, g1);
    mem_clr = 0;
    poke_en = 1; poke_addr = 12'h010; poke_data = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    step(rd(32'h40), none(), 0, g0, g1);
    poke_en = 0;
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);

    step(rd(32'h40), none(), 1, g0, g1);
    step(none(), none(), 1, g0, g1);
    chk("single_rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("single_rd_m1", m1_rvalid, 1'b0);

    step(none(), wr(32'h3FFC, 32'h12345678, 4'hF), 1, g0, g1);
    step(none(), rd(32'h3FFC), 1, g0, g1);
    chk("wr_old_data", m1_rdata, 32'h0);
    step(none(), none(), 1, g0, g1);
    chk("rd_new_data", m1_rdata, 32'h12345678);

    for (int i = 0; i < 12; i++) begin
      step(rd(32'h40), rd(32'h3FFC), 1, g0, g1);
      chk("starve_pat", g1, (i % 5) == 4);
    end
    step(none(), none(), 1, g0, g1);

    step(wr(32'h4000, 32'hCAFEF00D, 4'hF), none(), 1, g0, g1);
    step(rd(32'h0), none(), 1, g0, g1);
    chk("oor_err", m0_err, 1'b1);
    chk("oor_rdata", m0_rdata, 32'h0);
    step(none(), none(), 1, g0, g1);
    chk("oor_no_write", m0_rdata, 32'h0);

    for (int i = 0; i < 2; i++) step(rd(32'h40), rd(32'h3FFC), 1, g0, g1);
    step(rd(32'h40), none(), 1, g0, g1);
    step(rd(32'h44), none(), 0, g0, g1);
    step(rd(32'h44), none(), 0, g0, g1);
    chk("rst_mid_rvalid", m0_rvalid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(rd(32'h40), rd(32'h3FFC), 1, g0, g1);
      chk("post_rst_starve", g1, i == 4);
    end

    p0 = none(); p1 = none();
    for (int i = 0; i < 400; i++) begin
      if (!p0.req && $urandom_range(0, 99) < 70)
        p0 = $urandom_range(0, 1) ? rd({26'h0, 4'($urandom), 2'b0})
                                  : wr({26'h0, 4'($urandom), 2'b0},
                                       $urandom, 4'($urandom));
      if (!p1.req && $urandom_range(0, 99) < 50)
        p1 = $urandom_range(0, 1) ? rd({26'h0, 4'($urandom), 2'b0})
                                  : wr({26'h0, 4'($urandom), 2'b0},
                                       $urandom, 4'($urandom));
      if ($urandom_range(0, 19) == 0) p0.addr[16] = 1'b1;
      if ($urandom_range(0, 19) == 0) p1.addr[20] = 1'b1;
      step(p0, p1, 1, g0, g1);
      if (g0) p0 = none();
      if (g1) p1 = none();
    end

    for (int i = 0; i < 3; i++) step(none(), none(), 1, g0, g1);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    done = 1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
